// File: rtl/alu_operand_stage.sv
// Operand staging front-end for a 1's-complement ALU: collects a command and two
// parity-checked operand words, holds them on the ALU for a fixed latency, and returns the result.
module alu_operand_stage #(
  parameter int unsigned LAT_SIMPLE = 1,
  parameter int unsigned LAT_MULDIV = 2,
  parameter bit          PAR_CHECK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_word,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_cmd,
  input  logic [14:0] alu_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_res,
  output logic        par_err,
  output logic        op_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GET_A = 3'd1;
  localparam logic [2:0] GET_B = 3'd2;
  localparam logic [2:0] EXEC  = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  localparam logic [2:0] OP_MP0     = 3'd3;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam logic [3:0] CNT_SIMPLE = 4'(LAT_SIMPLE - 1);
  localparam logic [3:0] CNT_MULDIV = 4'(LAT_MULDIV - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [2:0]  op_q;
  logic [15:0] a_q;
  logic [3:0]  cnt;

  logic cmd_fire;
  logic in_fire;
  logic out_fire;
  logic word_ok;
  logic op_legal;
  logic cnt_done;

  // Handshakes qualify on the registered readies, so inputs are ignored wherever the ready is low.
  assign cmd_fire = cmd_valid && cmd_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign op_legal = (cmd_op != OP_ILLEGAL);
  assign cnt_done = (cnt == 4'd0);
  assign word_ok  = !PAR_CHECK || (^in_word);

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire && op_legal) state_nxt = GET_A;
      GET_A:   if (in_fire) state_nxt = word_ok ? GET_B : IDLE;
      GET_B:   if (in_fire) state_nxt = word_ok ? EXEC : IDLE;
      EXEC:    if (cnt_done) state_nxt = HOLD;
      HOLD:    if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      par_err   <= 1'b0;
      op_err    <= 1'b0;
      op_q      <= 3'd0;
      a_q       <= 16'd0;
      alu_a     <= 16'd0;
      alu_b     <= 16'd0;
      alu_cmd   <= 3'd0;
      out_res   <= 15'd0;
      cnt       <= 4'd0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);
      in_ready  <= (state_nxt == GET_A) || (state_nxt == GET_B);
      out_valid <= (state_nxt == HOLD);
      op_err    <= cmd_fire && !op_legal;
      par_err   <= in_fire && !word_ok;

      case (state)
        IDLE: begin
          if (cmd_fire && op_legal) op_q <= cmd_op;
        end
        GET_A: begin
          if (in_fire) begin
            if (word_ok) begin
              a_q <= {in_word[15:1], 1'b0};
            end else begin
              a_q  <= 16'd0;
              op_q <= 3'd0;
            end
          end
        end
        GET_B: begin
          if (in_fire) begin
            if (word_ok) begin
              // All three ALU inputs switch together on the EXEC entry edge.
              alu_a   <= a_q;
              alu_b   <= {in_word[15:1], 1'b0};
              alu_cmd <= op_q;
              cnt     <= (op_q >= OP_MP0) ? CNT_MULDIV : CNT_SIMPLE;
            end else begin
              a_q  <= 16'd0;
              op_q <= 3'd0;
            end
          end
        end
        EXEC: begin
          if (cnt_done) out_res <= alu_res;
          else          cnt     <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vector table, hand-written corner
// sequences and randomized transactions against a rule-level reference model.
module tb_alu_operand_stage;

  localparam int LAT_S = 1;
  localparam int LAT_M = 2;
  localparam int P_LAT_S = 3;
  localparam int WAIT_MAX = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic        in_valid, in_ready;
  logic [15:0] in_word;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_cmd;
  logic [14:0] alu_res;
  logic        out_valid, out_ready;
  logic [14:0] out_res;
  logic        par_err, op_err;

  // Second instance: parity check disabled, different latencies.
  logic        p_cmd_valid, p_cmd_ready;
  logic [2:0]  p_cmd_op;
  logic        p_in_valid, p_in_ready;
  logic [15:0] p_in_word;
  logic [15:0] p_alu_a, p_alu_b;
  logic [2:0]  p_alu_cmd;
  logic [14:0] p_alu_res;
  logic        p_out_valid, p_out_ready;
  logic [14:0] p_out_res;
  logic        p_par_err, p_op_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [14:0] res;
    int          hold;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    int          exp_lat;
  } vec_t;

  always #5 clk = ~clk;

  alu_operand_stage #(.LAT_SIMPLE(LAT_S), .LAT_MULDIV(LAT_M), .PAR_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_res(alu_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .par_err(par_err), .op_err(op_err)
  );

  alu_operand_stage #(.LAT_SIMPLE(P_LAT_S), .LAT_MULDIV(1), .PAR_CHECK(1'b0)) dut_nopar (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(p_cmd_valid), .cmd_ready(p_cmd_ready), .cmd_op(p_cmd_op),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_word(p_in_word),
    .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_cmd(p_alu_cmd), .alu_res(p_alu_res),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_res(p_out_res),
    .par_err(p_par_err), .op_err(p_op_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [2:0] op);
    return (op <= 3'd2) ? LAT_S : LAT_M;
  endfunction

  function automatic logic odd_parity(input logic [15:0] w);
    return ($countones(w) % 2) == 1;
  endfunction

  function automatic logic [54:0] all_outs();
    return {cmd_ready, in_ready, out_valid, par_err, op_err, alu_a, alu_b, alu_cmd, out_res};
  endfunction

  // All drive/sample activity happens on the falling edge.
  task automatic send_cmd(input logic [2:0] op);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    while (!cmd_ready && n < WAIT_MAX) begin @(negedge clk); n++; end
    check("cmd_ready wait", n < WAIT_MAX, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && n < WAIT_MAX) begin @(negedge clk); n++; end
    check("in_ready wait", n < WAIT_MAX, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_word  = 16'hDEAD;
  endtask

  task automatic run_good(input vec_t v);
    int   n;
    logic stable;
    alu_res   = ~v.res;
    out_ready = 1'b1;  // must be ignored outside HOLD
    send_cmd(v.op);
    check("in_ready after cmd", {in_ready, cmd_ready}, 2'b10);
    send_word(v.a);
    send_word(v.b);
    out_ready = 1'b0;
    check("alu_a at exec", alu_a, v.exp_a);
    check("alu_b at exec", alu_b, v.exp_b);
    check("alu_cmd at exec", alu_cmd, v.op);
    // The mock ALU shows the true result only just before the expected capture edge.
    stable  = 1'b1;
    n       = 0;
    alu_res = (v.exp_lat == 1) ? v.res : ~v.res;
    while (!out_valid && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
      alu_res = (n == v.exp_lat - 1) ? v.res : ~v.res;
      if (alu_a !== v.exp_a || alu_b !== v.exp_b || alu_cmd !== v.op || par_err) stable = 1'b0;
    end
    check("result latency", n, v.exp_lat);
    check("out_res", out_res, v.res);
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (!out_valid || out_res !== v.res || cmd_ready || alu_a !== v.exp_a ||
          alu_b !== v.exp_b || alu_cmd !== v.op) stable = 1'b0;
    end
    check("operands/result stable", stable, 1);
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("after out handshake", {out_valid, cmd_ready}, 2'b01);
  endtask

  task automatic run_par_err(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    send_cmd(op);
    send_word(a);
    if (odd_parity(a)) send_word(b);
    check("par_err pulse", {par_err, in_ready, cmd_ready, out_valid}, 4'b1010);
    @(negedge clk);
    check("par_err one cycle", {par_err, in_ready, cmd_ready, out_valid}, 4'b0010);
  endtask

  task automatic run_op_err();
    send_cmd(3'd7);
    check("op_err pulse", {op_err, in_ready, cmd_ready}, 3'b101);
    @(negedge clk);
    check("op_err one cycle", {op_err, in_ready, cmd_ready}, 3'b001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    int   n;

    vecs[0] = '{3'd0, 16'h0008, 16'h0007, 15'd7,      0, 16'h0008, 16'h0006, 1};
    vecs[1] = '{3'd3, 16'h0008, 16'h0007, 15'd12,     1, 16'h0008, 16'h0006, 2};
    vecs[2] = '{3'd1, 16'h0103, 16'h0010, 15'h1111,   5, 16'h0102, 16'h0010, 1};
    vecs[3] = '{3'd2, 16'hAAAB, 16'h5554, 15'h2AAA,   2, 16'hAAAA, 16'h5554, 1};
    vecs[4] = '{3'd4, 16'hFFFE, 16'hFFFE, 15'h7FFF,   0, 16'hFFFE, 16'hFFFE, 2};
    vecs[5] = '{3'd5, 16'h8000, 16'h0001, 15'h0000,   1, 16'h8000, 16'h0000, 2};
    vecs[6] = '{3'd6, 16'h0100, 16'h0200, 15'h4000,   3, 16'h0100, 16'h0200, 2};

    cmd_valid = 1'b0; cmd_op = 3'd0; in_valid = 1'b0; in_word = 16'd0;
    alu_res = 15'd0; out_ready = 1'b0;
    p_cmd_valid = 1'b0; p_cmd_op = 3'd0; p_in_valid = 1'b0; p_in_word = 16'd0;
    p_alu_res = 15'h1234; p_out_ready = 1'b0;

    // Reset state
    #12;
    check("outputs in reset", all_outs(), 55'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("cmd_ready before first edge", cmd_ready, 0);
    @(negedge clk);
    check("cmd_ready after first edge", {cmd_ready, in_ready, out_valid}, 3'b100);

    for (int i = 0; i < 7; i++) run_good(vecs[i]);

    // Even-parity B word, then illegal opcode
    run_par_err(3'd0, 16'h0008, 16'h0006);
    run_par_err(3'd3, 16'h0009, 16'h0007);
    run_op_err();
    run_good(vecs[0]);

    // Reset asserted in the middle of a DV1 execution
    out_ready = 1'b0;
    send_cmd(3'd6);
    send_word(16'h0008);
    send_word(16'h0007);
    #2 rst_n = 1'b0;
    #1 check("async reset clears outputs", all_outs(), 55'd0);
    repeat (3) @(negedge clk);
    check("outputs held in reset", all_outs(), 55'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset release", {cmd_ready, out_valid, par_err, op_err}, 4'b1000);
    run_good(vecs[0]);

    // Randomized transactions against the rule model
    for (int i = 0; i < 30; i++) begin
      logic [14:0] da, db;
      logic [15:0] a, b;
      int          corrupt;
      da = 15'($urandom);
      db = 15'($urandom);
      a  = {da, ~(^da)};
      b  = {db, ~(^db)};
      corrupt = $urandom_range(0, 7);
      if (corrupt == 0) a = a ^ 16'h0001;
      if (corrupt == 1) b = b ^ 16'h0400;
      v.op      = 3'($urandom_range(0, 7));
      v.a       = a;
      v.b       = b;
      v.res     = 15'($urandom);
      v.hold    = $urandom_range(0, 3);
      v.exp_a   = a & 16'hFFFE;
      v.exp_b   = b & 16'hFFFE;
      v.exp_lat = lat_of(v.op);
      if (v.op == 3'd7) run_op_err();
      else if (!odd_parity(a) || !odd_parity(b)) run_par_err(v.op, a, b);
      else run_good(v);
    end

    // Parity check disabled: the even-parity word is accepted as data
    p_cmd_valid = 1'b1;
    p_cmd_op    = 3'd0;
    n = 0;
    while (!p_cmd_ready && n < WAIT_MAX) begin @(negedge clk); n++; end
    @(negedge clk);
    p_cmd_valid = 1'b0;
    p_in_valid  = 1'b1;
    p_in_word   = 16'h0008;
    while (!p_in_ready && n < WAIT_MAX) begin @(negedge clk); n++; end
    @(negedge clk);
    p_in_word = 16'h0006;
    while (!p_in_ready && n < WAIT_MAX) begin @(negedge clk); n++; end
    @(negedge clk);
    p_in_valid = 1'b0;
    check("nopar handshakes", n < WAIT_MAX, 1);
    check("nopar no par_err", {p_par_err, p_in_ready}, 2'b00);
    check("nopar operands", {p_alu_a, p_alu_b}, {16'h0008, 16'h0006});
    n = 0;
    while (!p_out_valid && n < WAIT_MAX) begin @(negedge clk); n++; end
    check("nopar latency", n, P_LAT_S);
    check("nopar out_res", p_out_res, 15'h1234);
    p_out_ready = 1'b1;
    @(negedge clk);
    p_out_ready = 1'b0;
    check("nopar after out handshake", {p_out_valid, p_cmd_ready}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
